cp0_reg: RTL

//  Coprocessor-0 register file; sole consumer of wb_cp0_reg_we/_write_addr/_data from the MEM/WB register.

---
 rtl/cp0_reg_pkg.sv | 18 +
 rtl/cp0_timer.sv | 58 +++++
 rtl/cp0_reg.sv | 97 +++++++++
 3 files changed

// File: rtl/cp0_reg_pkg.sv
// Shared constants for the CP0 register file: register numbers and common words.
// Optional feature macro used by cp0_timer: CP0_COUNT_HALF_RATE_EN.
package cp0_reg_pkg;

    localparam logic [31:0] ZeroWord         = 32'h0000_0000;

    localparam logic [4:0]  CP0_REG_COUNT    = 5'd9;
    localparam logic [4:0]  CP0_REG_COMPARE  = 5'd11;
    localparam logic [4:0]  CP0_REG_STATUS   = 5'd12;
    localparam logic [4:0]  CP0_REG_CAUSE    = 5'd13;
    localparam logic [4:0]  CP0_REG_EPC      = 5'd14;
    localparam logic [4:0]  CP0_REG_PRID     = 5'd15;
    localparam logic [4:0]  CP0_REG_CONFIG   = 5'd16;

    // Cause bits software may write: IV(23), WP(22), IP1:0(9:8).
    localparam logic [31:0] CAUSE_WR_MASK    = 32'h00C0_0300;

endpackage

// File: rtl/cp0_timer.sv
// Count/Compare timer: free-running Count, Compare register and sticky timer interrupt.
// With CP0_COUNT_HALF_RATE_EN defined, Count steps every second cycle via a toggle flop.
module cp0_timer
    import cp0_reg_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        count_we,
    input  logic        compare_we,
    input  logic [31:0] data,
    output logic [31:0] count,
    output logic [31:0] compare,
    output logic        timer_int
);

    logic [31:0] count_q, compare_q;
    logic        timer_int_q;
    logic        inc;

`ifdef CP0_COUNT_HALF_RATE_EN
    logic toggle_q;

    // Toggle gates the increment; a Count write restarts the two-cycle phase.
    always_ff @(posedge clk) begin
        if (rst || count_we) toggle_q <= 1'b0;
        else                 toggle_q <= ~toggle_q;
    end

    assign inc = toggle_q;
`else
    assign inc = 1'b1;
`endif

    // Count: software write wins over the increment in the same cycle.
    always_ff @(posedge clk) begin
        if (rst)           count_q <= ZeroWord;
        else if (count_we) count_q <= data;
        else if (inc)      count_q <= count_q + 32'd1;
    end

    // Compare register.
    always_ff @(posedge clk) begin
        if (rst)             compare_q <= ZeroWord;
        else if (compare_we) compare_q <= data;
    end

    // Sticky timer interrupt: Compare write clears and beats a same-cycle match.
    always_ff @(posedge clk) begin
        if (rst)                                               timer_int_q <= 1'b0;
        else if (compare_we)                                   timer_int_q <= 1'b0;
        else if ((compare_q != ZeroWord) && (count_q == compare_q)) timer_int_q <= 1'b1;
    end

    assign count     = count_q;
    assign compare   = compare_q;
    assign timer_int = timer_int_q;

endmodule

// File: rtl/cp0_reg.sv
// Coprocessor-0 register file: Status/Cause/EPC storage, write decode, mfc0 read mux.
// Count/Compare live in cp0_timer; CP0_COUNT_HALF_RATE_EN selects its half-rate Count.
module cp0_reg
    import cp0_reg_pkg::*;
#(
    parameter logic [31:0] PRID_VALUE   = 32'h004C0102,
    parameter logic [31:0] CONFIG_VALUE = 32'h00008000,
    parameter logic [31:0] STATUS_RST   = 32'h10000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        we_i,
    input  logic [4:0]  waddr_i,
    input  logic [31:0] data_i,
    input  logic [4:0]  raddr_i,
    input  logic [5:0]  int_i,
    output logic [31:0] data_o,
    output logic [31:0] count_o,
    output logic [31:0] compare_o,
    output logic [31:0] status_o,
    output logic [31:0] cause_o,
    output logic [31:0] epc_o,
    output logic [31:0] config_o,
    output logic [31:0] prid_o,
    output logic        timer_int_o
);

    logic [31:0] status_q, cause_q, epc_q;
    logic        we_count, we_compare, we_status, we_cause, we_epc;

    // Write decode: one strobe per writable register.
    always_comb begin
        we_count   = we_i && (waddr_i == CP0_REG_COUNT);
        we_compare = we_i && (waddr_i == CP0_REG_COMPARE);
        we_status  = we_i && (waddr_i == CP0_REG_STATUS);
        we_cause   = we_i && (waddr_i == CP0_REG_CAUSE);
        we_epc     = we_i && (waddr_i == CP0_REG_EPC);
    end

    cp0_timer u_timer (
        .clk        (clk),
        .rst        (rst),
        .count_we   (we_count),
        .compare_we (we_compare),
        .data       (data_i),
        .count      (count_o),
        .compare    (compare_o),
        .timer_int  (timer_int_o)
    );

    // Status and EPC: plain full-width registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            status_q <= STATUS_RST;
            epc_q    <= ZeroWord;
        end else begin
            if (we_status) status_q <= data_i;
            if (we_epc)    epc_q    <= data_i;
        end
    end

    // Cause: IP7:2 track int_i every cycle; only IV/WP/IP1:0 are software-writable.
    always_ff @(posedge clk) begin
        if (rst) begin
            cause_q <= ZeroWord;
        end else begin
            if (we_cause) begin
                cause_q <= (cause_q & ~CAUSE_WR_MASK) | (data_i & CAUSE_WR_MASK);
            end
            cause_q[15:10] <= int_i;
        end
    end

    // Read mux: pre-edge register values, no bypass of the pending write.
    always_comb begin
        data_o = ZeroWord;
        if (!rst) begin
            case (raddr_i)
                CP0_REG_COUNT:   data_o = count_o;
                CP0_REG_COMPARE: data_o = compare_o;
                CP0_REG_STATUS:  data_o = status_q;
                CP0_REG_CAUSE:   data_o = cause_q;
                CP0_REG_EPC:     data_o = epc_q;
                CP0_REG_PRID:    data_o = PRID_VALUE;
                CP0_REG_CONFIG:  data_o = CONFIG_VALUE;
                default:         data_o = ZeroWord;
            endcase
        end
    end

    assign status_o = status_q;
    assign cause_o  = cause_q;
    assign epc_o    = epc_q;
    assign config_o = CONFIG_VALUE;
    assign prid_o   = PRID_VALUE;

endmodule
